// File: rtl/ram_arbiter_pkg.sv
// Shared types and default widths for the data-RAM arbiter.
package ram_arbiter_pkg;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_IO  = 1'b1
  } owner_t;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way grant logic: bit 0 = CPU, bit 1 = loader. Defining
// RAM_ARBITER_CPU_PRIORITY_EN makes the CPU win every tie.
module rr_arbiter2 (
  input  logic                    [1:0] req,
  input  ram_arbiter_pkg::owner_t       last_grant,
  output logic                    [1:0] grant
);
  import ram_arbiter_pkg::*;

  // One-hot grant from the current requests and the previous winner.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11: begin
`ifdef RAM_ARBITER_CPU_PRIORITY_EN
        grant = 2'b01;
`else
        if (last_grant == OWNER_IO) begin
          grant = 2'b01;
        end else begin
          grant = 2'b10;
        end
`endif
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single synchronous data-RAM port between the CPU MEM stage and
// the UART loader. Optional macro: RAM_ARBITER_CPU_PRIORITY_EN.
module ram_arbiter #(
  parameter int ADDR_W = ram_arbiter_pkg::ADDR_W,
  parameter int DATA_W = ram_arbiter_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_ready,
  output logic              io_rvalid,
  output logic [DATA_W-1:0] io_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_write_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_data
);
  import ram_arbiter_pkg::*;

  logic [1:0]        req_s;
  logic [1:0]        grant_s;
  owner_t            last_grant_q, last_grant_d;
  owner_t            pend_owner_q, pend_owner_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // Requests are masked while reset is held so every output reads 0.
  assign req_s = {io_req & reset_n, cpu_req & reset_n};

  rr_arbiter2 u_arb (
    .req        (req_s),
    .last_grant (last_grant_q),
    .grant      (grant_s)
  );

  // Drive the RAM from the winner and compute next arbitration state.
  always_comb begin
    last_grant_d   = last_grant_q;
    pend_owner_d   = pend_owner_q;
    pend_valid_d   = 1'b0;
    addr_d         = addr_q;
    ram_write_data = {DATA_W{1'b0}};
    ram_wren       = 1'b0;
    if (grant_s[0]) begin
      addr_d         = cpu_addr;
      ram_write_data = cpu_wdata;
      ram_wren       = cpu_we;
      last_grant_d   = OWNER_CPU;
      pend_valid_d   = ~cpu_we;
      pend_owner_d   = OWNER_CPU;
    end else if (grant_s[1]) begin
      addr_d         = io_addr;
      ram_write_data = io_wdata;
      ram_wren       = io_we;
      last_grant_d   = OWNER_IO;
      pend_valid_d   = ~io_we;
      pend_owner_d   = OWNER_IO;
    end else begin
      addr_d = addr_q;
    end
  end

  assign ram_address = addr_d;
  assign cpu_ready   = grant_s[0];
  assign io_ready    = grant_s[1];

  // Read return: the RAM answers one cycle after the address, routed to its owner.
  assign cpu_rvalid = pend_valid_q & (pend_owner_q == OWNER_CPU);
  assign io_rvalid  = pend_valid_q & (pend_owner_q == OWNER_IO);
  assign cpu_rdata  = cpu_rvalid ? ram_data : {DATA_W{1'b0}};
  assign io_rdata   = io_rvalid  ? ram_data : {DATA_W{1'b0}};

  // Arbitration state; last_grant resets to the loader so the CPU wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= OWNER_IO;
      pend_owner_q <= OWNER_CPU;
      pend_valid_q <= 1'b0;
      addr_q       <= {ADDR_W{1'b0}};
    end else begin
      last_grant_q <= last_grant_d;
      pend_owner_q <= pend_owner_d;
      pend_valid_q <= pend_valid_d;
      addr_q       <= addr_d;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed, table-driven bench for ram_arbiter with a write-first synchronous RAM model.
module tb_ram_arbiter;

  logic        clk;
  logic        reset_n;
  logic        cpu_req, cpu_we, io_req, io_we;
  logic [9:0]  cpu_addr, io_addr;
  logic [31:0] cpu_wdata, io_wdata;
  logic        cpu_ready, cpu_rvalid, io_ready, io_rvalid, ram_wren;
  logic [31:0] cpu_rdata, io_rdata, ram_write_data, ram_data;
  logic [9:0]  ram_address;
  logic [31:0] mem [0:1023];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        cr;  logic cwe; logic [9:0] ca; logic [31:0] cwd;
    logic        ir;  logic iwe; logic [9:0] ia; logic [31:0] iwd;
    logic        e_crdy; logic e_irdy;
    logic        e_crv;  logic [31:0] e_crd;
    logic        e_irv;  logic [31:0] e_ird;
    logic        e_wren; logic [9:0] e_addr; logic [31:0] e_wd;
  } vec_t;

  vec_t vecs [0:15];

  ram_arbiter dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cpu_req        (cpu_req),
    .cpu_we         (cpu_we),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_ready      (cpu_ready),
    .cpu_rvalid     (cpu_rvalid),
    .cpu_rdata      (cpu_rdata),
    .io_req         (io_req),
    .io_we          (io_we),
    .io_addr        (io_addr),
    .io_wdata       (io_wdata),
    .io_ready       (io_ready),
    .io_rvalid      (io_rvalid),
    .io_rdata       (io_rdata),
    .ram_address    (ram_address),
    .ram_write_data (ram_write_data),
    .ram_wren       (ram_wren),
    .ram_data       (ram_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-first synchronous RAM: read data appears one cycle after the address.
  always @(posedge clk) begin
    if (ram_wren) begin
      mem[ram_address] <= ram_write_data;
      ram_data         <= ram_write_data;
    end else begin
      ram_data <= mem[ram_address];
    end
  end

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%h expected=%h", name, idx, act, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    ram_data = 32'h0;

    //           cpu: req we addr wdata            io: req we addr wdata            exp: crdy irdy crv crd irv ird wren addr wd
    vecs[0] = '{1'b1,1'b1,10'h005,32'h0000_00AB, 1'b1,1'b1,10'h001,32'h0000_0011, 1'b1,1'b0,1'b0,32'h0,1'b0,32'h0,1'b1,10'h005,32'h0000_00AB};
    vecs[1] = '{1'b1,1'b1,10'h002,32'h0000_0022, 1'b1,1'b1,10'h001,32'h0000_0011, 1'b0,1'b1,1'b0,32'h0,1'b0,32'h0,1'b1,10'h001,32'h0000_0011};
    vecs[2] = '{1'b1,1'b1,10'h002,32'h0000_0022, 1'b0,1'b0,10'h000,32'h0,         1'b1,1'b0,1'b0,32'h0,1'b0,32'h0,1'b1,10'h002,32'h0000_0022};
    vecs[3] = '{1'b1,1'b0,10'h005,32'h0,         1'b0,1'b0,10'h000,32'h0,         1'b1,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,10'h005,32'h0};
    vecs[4] = '{1'b0,1'b0,10'h000,32'h0,         1'b0,1'b0,10'h000,32'h0,         1'b0,1'b0,1'b1,32'h0000_00AB,1'b0,32'h0,1'b0,10'h005,32'h0};
    vecs[5] = '{1'b0,1'b0,10'h000,32'h0,         1'b1,1'b0,10'h001,32'h0,         1'b0,1'b1,1'b0,32'h0,1'b0,32'h0,1'b0,10'h001,32'h0};
    vecs[6] = '{1'b1,1'b0,10'h002,32'h0,         1'b0,1'b0,10'h000,32'h0,         1'b1,1'b0,1'b0,32'h0,1'b1,32'h0000_0011,1'b0,10'h002,32'h0};
    vecs[7] = '{1'b0,1'b0,10'h000,32'h0,         1'b1,1'b0,10'h001,32'h0,         1'b0,1'b1,1'b1,32'h0000_0022,1'b0,32'h0,1'b0,10'h001,32'h0};
    // Six cycles of both requesters reading: CPU from 0x005, loader from 0x002.
    for (int k = 8; k < 14; k++) begin
      vecs[k] = '{1'b1,1'b0,10'h005,32'h0, 1'b1,1'b0,10'h002,32'h0, 1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,10'h000,32'h0};
`ifdef RAM_ARBITER_CPU_PRIORITY_EN
      vecs[k].e_crdy = 1'b1;
      vecs[k].e_addr = 10'h005;
      if (k == 8) begin
        vecs[k].e_irv = 1'b1; vecs[k].e_ird = 32'h0000_0011;
      end else begin
        vecs[k].e_crv = 1'b1; vecs[k].e_crd = 32'h0000_00AB;
      end
`else
      if (k % 2 == 0) begin
        vecs[k].e_crdy = 1'b1; vecs[k].e_addr = 10'h005;
        vecs[k].e_irv  = 1'b1;
        vecs[k].e_ird  = (k == 8) ? 32'h0000_0011 : 32'h0000_0022;
      end else begin
        vecs[k].e_irdy = 1'b1; vecs[k].e_addr = 10'h002;
        vecs[k].e_crv  = 1'b1; vecs[k].e_crd  = 32'h0000_00AB;
      end
`endif
    end
`ifdef RAM_ARBITER_CPU_PRIORITY_EN
    vecs[14] = '{1'b0,1'b0,10'h000,32'h0, 1'b1,1'b0,10'h002,32'h0, 1'b0,1'b1,1'b1,32'h0000_00AB,1'b0,32'h0,1'b0,10'h002,32'h0};
`else
    vecs[14] = '{1'b0,1'b0,10'h000,32'h0, 1'b1,1'b0,10'h002,32'h0, 1'b0,1'b1,1'b0,32'h0,1'b1,32'h0000_0022,1'b0,10'h002,32'h0};
`endif
    vecs[15] = '{1'b0,1'b0,10'h000,32'h0, 1'b0,1'b0,10'h000,32'h0, 1'b0,1'b0,1'b0,32'h0,1'b1,32'h0000_0022,1'b0,10'h002,32'h0};

    // Reset held with both requesters active: everything must read 0.
    reset_n = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h3FF; cpu_wdata = 32'hDEAD_BEEF;
    io_req  = 1'b1; io_we  = 1'b1; io_addr  = 10'h155; io_wdata  = 32'hCAFE_F00D;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_cpu_ready",  0, {31'b0, cpu_ready},  32'h0);
    chk("rst_io_ready",   0, {31'b0, io_ready},   32'h0);
    chk("rst_cpu_rvalid", 0, {31'b0, cpu_rvalid}, 32'h0);
    chk("rst_io_rvalid",  0, {31'b0, io_rvalid},  32'h0);
    chk("rst_cpu_rdata",  0, cpu_rdata,           32'h0);
    chk("rst_io_rdata",   0, io_rdata,            32'h0);
    chk("rst_ram_wren",   0, {31'b0, ram_wren},   32'h0);
    chk("rst_ram_addr",   0, {22'b0, ram_address}, 32'h0);
    chk("rst_ram_wdata",  0, ram_write_data,      32'h0);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      cpu_req = vecs[i].cr; cpu_we = vecs[i].cwe; cpu_addr = vecs[i].ca; cpu_wdata = vecs[i].cwd;
      io_req  = vecs[i].ir; io_we  = vecs[i].iwe; io_addr  = vecs[i].ia; io_wdata  = vecs[i].iwd;
      reset_n = 1'b1;
      #2;
      chk("cpu_ready",  i, {31'b0, cpu_ready},   {31'b0, vecs[i].e_crdy});
      chk("io_ready",   i, {31'b0, io_ready},    {31'b0, vecs[i].e_irdy});
      chk("cpu_rvalid", i, {31'b0, cpu_rvalid},  {31'b0, vecs[i].e_crv});
      chk("cpu_rdata",  i, cpu_rdata,            vecs[i].e_crd);
      chk("io_rvalid",  i, {31'b0, io_rvalid},   {31'b0, vecs[i].e_irv});
      chk("io_rdata",   i, io_rdata,             vecs[i].e_ird);
      chk("ram_wren",   i, {31'b0, ram_wren},    {31'b0, vecs[i].e_wren});
      chk("ram_address", i, {22'b0, ram_address}, {22'b0, vecs[i].e_addr});
      if (vecs[i].e_wren) chk("ram_wdata", i, ram_write_data, vecs[i].e_wd);
    end

    // Reset pulsed inside the grant cycle of a CPU read: no rvalid may follow.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h005; io_req = 1'b0;
    #2;
    chk("midA_ready", 100, {31'b0, cpu_ready}, 32'h1);
    #1;
    reset_n = 1'b0; cpu_req = 1'b0;
    #1;
    chk("midA_rst_ready", 101, {31'b0, cpu_ready},    32'h0);
    chk("midA_rst_addr",  101, {22'b0, ram_address},  32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    #2;
    chk("midA_rvalid", 102, {31'b0, cpu_rvalid}, 32'h0);
    chk("midA_rdata",  102, cpu_rdata,           32'h0);

    // Reset arriving while read data is being returned clears it immediately.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h005;
    #2;
    chk("midB_ready", 110, {31'b0, cpu_ready}, 32'h1);
    @(negedge clk);
    cpu_req = 1'b0;
    #2;
    chk("midB_rvalid", 111, {31'b0, cpu_rvalid}, 32'h1);
    chk("midB_rdata",  111, cpu_rdata,           32'h0000_00AB);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midB_rst_rvalid", 112, {31'b0, cpu_rvalid}, 32'h0);
    chk("midB_rst_rdata",  112, cpu_rdata,           32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    #2;
    chk("midB_after_rvalid", 113, {31'b0, cpu_rvalid}, 32'h0);

    // After reset the CPU again wins a tie.
    @(negedge clk);
    cpu_req = 1'b1; io_req = 1'b1; cpu_we = 1'b0; io_we = 1'b0;
    #2;
    chk("post_rst_cpu_ready", 120, {31'b0, cpu_ready}, 32'h1);
    chk("post_rst_io_ready",  120, {31'b0, io_ready},  32'h0);
    @(negedge clk);
    cpu_req = 1'b0; io_req = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
